// File: rtl/dmux.sv
// rtl/dmux.sv - 1:2 demultiplexer with a combinational path, a registered path and saturating per-channel route counters
module dmux #(
    parameter int WIDTH = 1,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] in,
    input  logic             sel,
    input  logic             in_valid,
    output logic [WIDTH-1:0] a,
    output logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] a_q,
    output logic [WIDTH-1:0] b_q,
    output logic             a_valid,
    output logic             b_valid,
    output logic [CNT_W-1:0] cnt_a,
    output logic [CNT_W-1:0] cnt_b
);

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    // Zero-latency routing; the unselected channel is always driven to zero
    always_comb begin
        a = '0;
        b = '0;
        if (sel) begin
            b = in;
        end else begin
            a = in;
        end
    end

    // Registered copy of the routing; data holds when no valid transfer arrives
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_q     <= '0;
            b_q     <= '0;
            a_valid <= 1'b0;
            b_valid <= 1'b0;
        end else if (in_valid) begin
            if (sel) begin
                a_q     <= '0;
                b_q     <= in;
                a_valid <= 1'b0;
                b_valid <= 1'b1;
            end else begin
                a_q     <= in;
                b_q     <= '0;
                a_valid <= 1'b1;
                b_valid <= 1'b0;
            end
        end else begin
            a_valid <= 1'b0;
            b_valid <= 1'b0;
        end
    end

    // Per-channel transfer counters that stick at all-ones instead of wrapping
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_a <= '0;
            cnt_b <= '0;
        end else if (in_valid) begin
            if (sel) begin
                if (cnt_b != CNT_MAX) begin
                    cnt_b <= cnt_b + CNT_ONE;
                end
            end else begin
                if (cnt_a != CNT_MAX) begin
                    cnt_a <= cnt_a + CNT_ONE;
                end
            end
        end
    end

endmodule

// File: tb/tb_dmux.sv
// tb/tb_dmux.sv - directed self-checking bench for dmux
module tb_dmux;

    localparam int WIDTH = 8;
    localparam int CNT_W = 2;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic [WIDTH-1:0] in = '0;
    logic             sel = 1'b0;
    logic             in_valid = 1'b0;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic             a_valid;
    logic             b_valid;
    logic [CNT_W-1:0] cnt_a;
    logic [CNT_W-1:0] cnt_b;

    int tests = 0;
    int fails = 0;

    dmux #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .clk      (clk),
        .rst      (rst),
        .in       (in),
        .sel      (sel),
        .in_valid (in_valid),
        .a        (a),
        .b        (b),
        .a_q      (a_q),
        .b_q      (b_q),
        .a_valid  (a_valid),
        .b_valid  (b_valid),
        .cnt_a    (cnt_a),
        .cnt_b    (cnt_b)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_regs(input string tag, input logic [7:0] eaq, input logic [7:0] ebq,
                              input logic eav, input logic ebv, input logic [1:0] eca,
                              input logic [1:0] ecb);
        check({tag, ".a_q"}, 32'(a_q), 32'(eaq));
        check({tag, ".b_q"}, 32'(b_q), 32'(ebq));
        check({tag, ".a_valid"}, 32'(a_valid), 32'(eav));
        check({tag, ".b_valid"}, 32'(b_valid), 32'(ebv));
        check({tag, ".cnt_a"}, 32'(cnt_a), 32'(eca));
        check({tag, ".cnt_b"}, 32'(cnt_b), 32'(ecb));
    endtask

    initial begin
        // Assert reset away from any clock edge
        #1 rst = 1'b1;
        #1;
        check_regs("reset", 8'h00, 8'h00, 1'b0, 1'b0, 2'd0, 2'd0);

        // Combinational path while in reset, no clock edge between steps
        in = 8'h00; sel = 1'b0; #1;
        check("comb_in0_sel0.a", 32'(a), 32'h00);
        check("comb_in0_sel0.b", 32'(b), 32'h00);
        sel = 1'b1; #1;
        check("comb_in0_sel1.a", 32'(a), 32'h00);
        check("comb_in0_sel1.b", 32'(b), 32'h00);
        in = 8'h01; #1;
        check("comb_in1_sel1.a", 32'(a), 32'h00);
        check("comb_in1_sel1.b", 32'(b), 32'h01);
        sel = 1'b0; #1;
        check("comb_in1_sel0.a", 32'(a), 32'h01);
        check("comb_in1_sel0.b", 32'(b), 32'h00);

        // Release reset mid-cycle; first edge must be processed normally
        @(negedge clk);
        rst = 1'b0;
        in = 8'hA5; sel = 1'b1; in_valid = 1'b1;
        tick();
        check_regs("first_b", 8'h00, 8'hA5, 1'b0, 1'b1, 2'd0, 2'd1);

        // Idle edge: strobes drop, data holds, comb path follows new inputs
        in = 8'h3C; sel = 1'b0; in_valid = 1'b0;
        tick();
        check_regs("idle", 8'h00, 8'hA5, 1'b0, 1'b0, 2'd0, 2'd1);
        check("idle_comb.a", 32'(a), 32'h3C);
        check("idle_comb.b", 32'(b), 32'h00);

        // Fresh counters, then five valid edges to channel a
        #2 rst = 1'b1;
        #1 rst = 1'b0;
        check_regs("reset2", 8'h00, 8'h00, 1'b0, 1'b0, 2'd0, 2'd0);
        in_valid = 1'b1; sel = 1'b0;
        in = 8'h11; tick(); check_regs("sat1", 8'h11, 8'h00, 1'b1, 1'b0, 2'd1, 2'd0);
        in = 8'h22; tick(); check_regs("sat2", 8'h22, 8'h00, 1'b1, 1'b0, 2'd2, 2'd0);
        in = 8'h33; tick(); check_regs("sat3", 8'h33, 8'h00, 1'b1, 1'b0, 2'd3, 2'd0);
        in = 8'h44; tick(); check_regs("sat4", 8'h44, 8'h00, 1'b1, 1'b0, 2'd3, 2'd0);
        in = 8'h55; tick(); check_regs("sat5", 8'h55, 8'h00, 1'b1, 1'b0, 2'd3, 2'd0);

        // Switch to b: a_q cleared, only cnt_b moves
        in = 8'h66; sel = 1'b1; tick();
        check_regs("switch_b", 8'h00, 8'h66, 1'b0, 1'b1, 2'd3, 2'd1);
        in = 8'h77; tick();
        check_regs("b2", 8'h00, 8'h77, 1'b0, 1'b1, 2'd3, 2'd2);
        in = 8'h88; tick();
        check_regs("b3", 8'h00, 8'h88, 1'b0, 1'b1, 2'd3, 2'd3);
        in = 8'h99; tick();
        check_regs("b_sat", 8'h00, 8'h99, 1'b0, 1'b1, 2'd3, 2'd3);

        // Three transfers, then reset between edges discards everything
        #2 rst = 1'b1;
        #1 rst = 1'b0;
        in = 8'h01; sel = 1'b0; tick();
        in = 8'h02; sel = 1'b1; tick();
        in = 8'h03; sel = 1'b0; tick();
        check_regs("pre_rst", 8'h03, 8'h00, 1'b1, 1'b0, 2'd2, 2'd1);
        #2 rst = 1'b1;
        #1;
        check_regs("mid_rst", 8'h00, 8'h00, 1'b0, 1'b0, 2'd0, 2'd0);
        check("mid_rst_comb.a", 32'(a), 32'h03);
        check("mid_rst_comb.b", 32'(b), 32'h00);
        in = 8'hC3; sel = 1'b1; #1;
        check("mid_rst_comb2.a", 32'(a), 32'h00);
        check("mid_rst_comb2.b", 32'(b), 32'hC3);

        // Edge while held in reset changes nothing
        tick();
        check_regs("held_rst", 8'h00, 8'h00, 1'b0, 1'b0, 2'd0, 2'd0);

        // Release and confirm the next edge is live
        @(negedge clk);
        rst = 1'b0;
        in = 8'h5A; sel = 1'b1; in_valid = 1'b1;
        tick();
        check_regs("post_rst", 8'h00, 8'h5A, 1'b0, 1'b1, 2'd0, 2'd1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
